// File: rtl/input_channel_buffer.sv
// Input channel buffer: circular packet FIFO between an upstream link and a PE input channel.
// Link and input-channel bundles are flattened into individual ports.
module input_channel_buffer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PACKET_WIDTH = 32,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    link_req,
  input  logic [PACKET_WIDTH-1:0] link_packet,
  output logic                    link_ack,
  output logic [PACKET_WIDTH-1:0] input_channel_packet,
  output logic                    input_channel_empty,
  output logic [CNT_W-1:0]        input_channel_count,
  input  logic                    input_channel_dequeue,
  output logic                    underflow,
  output logic                    quiescent
);

  logic [PACKET_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    underflow_q, underflow_d;
  logic                    full;
  logic                    accept;
  logic                    deq_valid;
  logic                    deq_empty;

  // A full buffer never accepts, even when the head is leaving this cycle.
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign accept    = enable && link_req && !full;
  assign deq_valid = enable && input_channel_dequeue && (count_q != '0);
  assign deq_empty = enable && input_channel_dequeue && (count_q == '0);

  assign link_ack             = accept && !reset;
  assign input_channel_packet = fifo_q[head_q];
  assign input_channel_empty  = (count_q == '0);
  assign input_channel_count  = count_q;
  assign quiescent            = (count_q == '0);
  assign underflow            = underflow_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    underflow_d = underflow_q | deq_empty;
    if (accept) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (deq_valid) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({accept, deq_valid})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a stray write while reset is held lands in a slot treated as empty.
  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_q[tail_q] <= link_packet;
    end
  end

endmodule
